// File: rtl/riscv_id_stage.sv
// riscv_id_stage: RV32I (+MUL) decoder fused with the ID/EX pipeline register.
// It adds a valid/ready handshake, load-use bubbles, flush and illegal flagging.
module riscv_id_stage #(
  parameter int XLEN       = 32,
  parameter bit ENABLE_MUL = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [31:0]      in_instr,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_rs1_data,
  output logic [XLEN-1:0]  out_rs2_data,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic [3:0]       out_alu_op,
  output logic [2:0]       out_funct3,
  output logic             out_alu_src_imm,
  output logic             out_is_load,
  output logic             out_is_store,
  output logic             out_is_branch,
  output logic             out_is_jump,
  output logic             out_reg_write,
  output logic [1:0]       out_wb_sel,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_AND = 4'd1, ALU_OR = 4'd2, ALU_XOR = 4'd3,
    ALU_SLL = 4'd4, ALU_SRL = 4'd5, ALU_SUB = 4'd6, ALU_CMP = 4'd7,
    ALU_SRA = 4'd8, ALU_SLT = 4'd9, ALU_MUL = 4'd10, ALU_SLTU = 4'd11,
    ALU_PASSB = 4'd12
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic [2:0]      funct3;
    logic            alu_src_imm;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            is_jump;
    logic            reg_write;
    logic [1:0]      wb_sel;
    logic            illegal;
  } id_ex_t;

  // Shared funct3 mapping for OP and OP-IMM; alt selects SRA, sub selects SUB.
  function automatic logic [3:0] base_op(input logic [2:0] f3, input logic alt, input logic sub);
    case (f3)
      3'b000:  base_op = sub ? ALU_SUB : ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

  logic [6:0]      opcode;
  logic [6:0]      funct7;
  logic [XLEN-1:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  logic [XLEN-1:0] dec_imm;
  logic [3:0]      dec_alu_op;
  logic            dec_src_imm, dec_load, dec_store, dec_branch, dec_jump;
  logic            dec_writes_rd, dec_illegal;
  logic [1:0]      dec_wb_sel;
  logic            uses_rs1, uses_rs2, advance, hazard, clear_ctrl;
  id_ex_t          id_ex_d, id_ex_q;
  logic            valid_d, valid_q;
  logic [CNT_W-1:0] stall_d, stall_q;

  assign opcode   = in_instr[6:0];
  assign funct7   = in_instr[31:25];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  assign i_imm = {{(XLEN-11){in_instr[31]}}, in_instr[30:20]};
  assign s_imm = {{(XLEN-11){in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
  assign b_imm = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign u_imm = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
  assign j_imm = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  assign uses_rs1 = !(opcode == OPC_LUI || opcode == OPC_JAL || opcode == OPC_AUIPC);
  assign uses_rs2 = (opcode == OPC_OP || opcode == OPC_STORE || opcode == OPC_BRANCH);

  // Only a load still sitting in ID/EX can create a dependency that forwarding cannot cover.
  assign advance  = !valid_q || out_ready;
  assign hazard   = in_valid && valid_q && id_ex_q.is_load && (id_ex_q.rd != 5'd0) &&
                    ((uses_rs1 && rs1_addr == id_ex_q.rd) || (uses_rs2 && rs2_addr == id_ex_q.rd));
  assign in_ready = flush || (advance && !hazard);

  // Combinational decode of the instruction presented by fetch.
  always_comb begin
    dec_imm       = '0;
    dec_alu_op    = ALU_ADD;
    dec_src_imm   = 1'b0;
    dec_load      = 1'b0;
    dec_store     = 1'b0;
    dec_branch    = 1'b0;
    dec_jump      = 1'b0;
    dec_writes_rd = 1'b0;
    dec_wb_sel    = 2'd0;
    dec_illegal   = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        dec_alu_op = base_op(in_instr[14:12], in_instr[30], 1'b0);
        dec_src_imm = 1'b1; dec_imm = i_imm; dec_writes_rd = 1'b1;
      end
      OPC_OP: begin
        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          dec_alu_op = base_op(in_instr[14:12], in_instr[30], in_instr[30]);
          dec_writes_rd = 1'b1;
        end else if (funct7 == 7'b0000001 && ENABLE_MUL) begin
          dec_alu_op = ALU_MUL; dec_writes_rd = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_LOAD: begin
        dec_src_imm = 1'b1; dec_imm = i_imm; dec_load = 1'b1;
        dec_writes_rd = 1'b1; dec_wb_sel = 2'd1;
      end
      OPC_STORE: begin
        dec_src_imm = 1'b1; dec_imm = s_imm; dec_store = 1'b1;
      end
      OPC_BRANCH: begin
        dec_alu_op = ALU_CMP; dec_imm = b_imm; dec_branch = 1'b1;
      end
      OPC_JAL: begin
        dec_src_imm = 1'b1; dec_imm = j_imm; dec_jump = 1'b1;
        dec_writes_rd = 1'b1; dec_wb_sel = 2'd2;
      end
      OPC_JALR: begin
        dec_src_imm = 1'b1; dec_imm = i_imm; dec_jump = 1'b1;
        dec_writes_rd = 1'b1; dec_wb_sel = 2'd2;
      end
      OPC_LUI: begin
        dec_alu_op = ALU_PASSB; dec_src_imm = 1'b1; dec_imm = u_imm; dec_writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        dec_src_imm = 1'b1; dec_imm = u_imm; dec_writes_rd = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Next-state for the ID/EX register: flush, then bubble, then capture, then drain, else hold.
  always_comb begin
    id_ex_d    = id_ex_q;
    valid_d    = valid_q;
    stall_d    = stall_q;
    clear_ctrl = 1'b0;
    if (flush) begin
      valid_d = 1'b0; clear_ctrl = 1'b1;
    end else if (advance && hazard) begin
      valid_d = 1'b0; clear_ctrl = 1'b1;
      stall_d = (&stall_q) ? stall_q : stall_q + CNT_W'(1);
    end else if (advance && in_valid) begin
      valid_d             = 1'b1;
      id_ex_d.pc          = in_pc;
      id_ex_d.rs1_data    = rs1_data;
      id_ex_d.rs2_data    = rs2_data;
      id_ex_d.rd          = dec_writes_rd ? in_instr[11:7] : 5'd0;
      id_ex_d.imm         = dec_imm;
      id_ex_d.alu_op      = dec_alu_op;
      id_ex_d.funct3      = in_instr[14:12];
      id_ex_d.alu_src_imm = dec_src_imm;
      id_ex_d.is_load     = dec_load;
      id_ex_d.is_store    = dec_store;
      id_ex_d.is_branch   = dec_branch;
      id_ex_d.is_jump     = dec_jump;
      id_ex_d.reg_write   = dec_writes_rd && (in_instr[11:7] != 5'd0);
      id_ex_d.wb_sel      = dec_wb_sel;
      id_ex_d.illegal     = dec_illegal;
    end else if (advance) begin
      valid_d = 1'b0; clear_ctrl = 1'b1;
    end
    if (clear_ctrl) begin
      id_ex_d.alu_op      = '0;
      id_ex_d.alu_src_imm = 1'b0;
      id_ex_d.is_load     = 1'b0;
      id_ex_d.is_store    = 1'b0;
      id_ex_d.is_branch   = 1'b0;
      id_ex_d.is_jump     = 1'b0;
      id_ex_d.reg_write   = 1'b0;
      id_ex_d.wb_sel      = '0;
      id_ex_d.illegal     = 1'b0;
    end
  end

  // Pipeline register and stall counter with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q <= '0;
      valid_q <= 1'b0;
      stall_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
    end
  end

  assign out_valid       = valid_q;
  assign out_pc          = id_ex_q.pc;
  assign out_rs1_data    = id_ex_q.rs1_data;
  assign out_rs2_data    = id_ex_q.rs2_data;
  assign out_rd          = id_ex_q.rd;
  assign out_imm         = id_ex_q.imm;
  assign out_alu_op      = id_ex_q.alu_op;
  assign out_funct3      = id_ex_q.funct3;
  assign out_alu_src_imm = id_ex_q.alu_src_imm;
  assign out_is_load     = id_ex_q.is_load;
  assign out_is_store    = id_ex_q.is_store;
  assign out_is_branch   = id_ex_q.is_branch;
  assign out_is_jump     = id_ex_q.is_jump;
  assign out_reg_write   = id_ex_q.reg_write;
  assign out_wb_sel      = id_ex_q.wb_sel;
  assign out_illegal     = id_ex_q.illegal;
  assign stall_count     = stall_q;

endmodule

// File: tb/tb_riscv_id_stage.sv
// tb_riscv_id_stage: directed vector table plus hand-written handshake sequences.
module tb_riscv_id_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_instr, rs1_data, rs2_data;

  logic        in_ready, out_valid, out_alu_src_imm, out_is_load, out_is_store;
  logic        out_is_branch, out_is_jump, out_reg_write, out_illegal;
  logic [4:0]  rs1_addr, rs2_addr, out_rd;
  logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [3:0]  out_alu_op;
  logic [2:0]  out_funct3;
  logic [1:0]  out_wb_sel;
  logic [15:0] stall_count;

  logic        nm_in_ready, nm_out_valid, nm_out_alu_src_imm, nm_out_is_load, nm_out_is_store;
  logic        nm_out_is_branch, nm_out_is_jump, nm_out_reg_write, nm_out_illegal;
  logic [4:0]  nm_rs1_addr, nm_rs2_addr, nm_out_rd;
  logic [31:0] nm_out_pc, nm_out_rs1_data, nm_out_rs2_data, nm_out_imm;
  logic [3:0]  nm_out_alu_op;
  logic [2:0]  nm_out_funct3;
  logic [1:0]  nm_out_wb_sel;
  logic [1:0]  nm_stall_count;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  riscv_id_stage #(.XLEN(32), .ENABLE_MUL(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_imm(out_imm), .out_alu_op(out_alu_op), .out_funct3(out_funct3),
    .out_alu_src_imm(out_alu_src_imm), .out_is_load(out_is_load), .out_is_store(out_is_store),
    .out_is_branch(out_is_branch), .out_is_jump(out_is_jump), .out_reg_write(out_reg_write),
    .out_wb_sel(out_wb_sel), .out_illegal(out_illegal), .stall_count(stall_count)
  );

  riscv_id_stage #(.XLEN(32), .ENABLE_MUL(1'b0), .CNT_W(2)) dut_nm (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(nm_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .rs1_addr(nm_rs1_addr), .rs2_addr(nm_rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(nm_out_valid), .out_ready(out_ready),
    .out_pc(nm_out_pc), .out_rs1_data(nm_out_rs1_data), .out_rs2_data(nm_out_rs2_data),
    .out_rd(nm_out_rd), .out_imm(nm_out_imm), .out_alu_op(nm_out_alu_op), .out_funct3(nm_out_funct3),
    .out_alu_src_imm(nm_out_alu_src_imm), .out_is_load(nm_out_is_load), .out_is_store(nm_out_is_store),
    .out_is_branch(nm_out_is_branch), .out_is_jump(nm_out_is_jump), .out_reg_write(nm_out_reg_write),
    .out_wb_sel(nm_out_wb_sel), .out_illegal(nm_out_illegal), .stall_count(nm_stall_count)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  op;
    logic        src, ld, st, br, jp, rw;
    logic [1:0]  wb;
    logic        ill;
  } vec_t;

  vec_t vecs [18];

  // One comparison: counts it, and reports actual versus required on a miss.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one instruction for a single cycle and sample one cycle later.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                               input logic [31:0] d1, input logic [31:0] d2);
    in_instr = instr; in_pc = pc; rs1_data = d1; rs2_data = d2; in_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idleCycle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // lw rd,0(x1) then add x3,rd,x1 which must cost one bubble.
  task automatic loadUse(input logic [4:0] rd);
    applyStimulus({12'd0, 5'd1, 3'b010, rd, 7'h03}, 32'h200, 32'h0, 32'h0);
    in_instr = {7'd0, 5'd1, rd, 3'b000, 5'd3, 7'h33};
    @(posedge clk); #1;
    @(posedge clk); #1;
    idleCycle();
  endtask

  initial begin
    vec_t v;
    logic [12:0] exp_ctrl;
    logic [12:0] act_ctrl;

    //        instr         imm           rd  op   src ld st br jp rw wb  ill
    vecs[0]  = '{32'h00500093, 32'h00000005, 5'd1, 4'd0,  1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,1'b0};
    vecs[1]  = '{32'h001101B3, 32'h00000000, 5'd3, 4'd0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,1'b0};
    vecs[2]  = '{32'h407302B3, 32'h00000000, 5'd5, 4'd6,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,1'b0};
    vecs[3]  = '{32'h407352B3, 32'h00000000, 5'd5, 4'd8,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,1'b0};
    vecs[4]  = '{32'h007332B3, 32'h00000000, 5'd5, 4'd11, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,1'b0};
    vecs[5]  = '{32'h027302B3, 32'h00000000, 5'd5, 4'd10, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,1'b0};
    vecs[6]  = '{32'hFFC0A103, 32'hFFFFFFFC, 5'd2, 4'd0,  1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,2'd1,1'b0};
    vecs[7]  = '{32'h0020A423, 32'h00000008, 5'd0, 4'd0,  1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,1'b0};
    vecs[8]  = '{32'hFE208CE3, 32'hFFFFFFF8, 5'd0, 4'd7,  1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,1'b0};
    vecs[9]  = '{32'h010000EF, 32'h00000010, 5'd1, 4'd0,  1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,2'd2,1'b0};
    vecs[10] = '{32'h00008067, 32'h00000000, 5'd0, 4'd0,  1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,2'd2,1'b0};
    vecs[11] = '{32'h123452B7, 32'h12345000, 5'd5, 4'd12, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,1'b0};
    vecs[12] = '{32'hFFFFF317, 32'hFFFFF000, 5'd6, 4'd0,  1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,1'b0};
    vecs[13] = '{32'h40345393, 32'h00000403, 5'd7, 4'd8,  1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,1'b0};
    vecs[14] = '{32'h0000007F, 32'h00000000, 5'd0, 4'd0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b1};
    vecs[15] = '{32'h207302B3, 32'h00000000, 5'd0, 4'd0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b1};
    vecs[16] = '{32'hFFF0C093, 32'hFFFFFFFF, 5'd1, 4'd3,  1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,1'b0};
    vecs[17] = '{32'h00000013, 32'h00000000, 5'd0, 4'd0,  1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_instr = 32'h00000013; rs1_data = '0; rs2_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset stall_count", 64'(stall_count), 64'd0);
    checkOutput("reset reg_write", 64'(out_reg_write), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle in_ready", 64'(in_ready), 64'd1);

    // Decode table: each vector for one cycle followed by an idle cycle.
    for (int i = 0; i < 18; i++) begin
      v = vecs[i];
      applyStimulus(v.instr, 32'h1000 + 32'(i * 4), 32'hA0000000 + 32'(i), 32'hB0000000 + 32'(i));
      exp_ctrl = {v.op, v.src, v.ld, v.st, v.br, v.jp, v.rw, v.wb, v.ill};
      act_ctrl = {out_alu_op, out_alu_src_imm, out_is_load, out_is_store, out_is_branch,
                  out_is_jump, out_reg_write, out_wb_sel, out_illegal};
      checkOutput($sformatf("vec%0d valid", i), 64'(out_valid), 64'd1);
      checkOutput($sformatf("vec%0d ctrl", i), 64'(act_ctrl), 64'(exp_ctrl));
      checkOutput($sformatf("vec%0d imm", i), 64'(out_imm), 64'(v.imm));
      checkOutput($sformatf("vec%0d rd", i), 64'(out_rd), 64'(v.rd));
      checkOutput($sformatf("vec%0d pc", i), 64'(out_pc), 64'(32'h1000 + 32'(i * 4)));
      checkOutput($sformatf("vec%0d rs1d", i), 64'(out_rs1_data), 64'(32'hA0000000 + 32'(i)));
      checkOutput($sformatf("vec%0d rs2d", i), 64'(out_rs2_data), 64'(32'hB0000000 + 32'(i)));
      idleCycle();
      checkOutput($sformatf("vec%0d drain", i), 64'(out_valid), 64'd0);
    end

    // Branch funct3 is passed through: bne x1,x2,-8.
    applyStimulus(32'hFE209CE3, 32'h0, 32'h0, 32'h0);
    checkOutput("bne funct3", 64'(out_funct3), 64'd1);
    idleCycle();

    // Load-use: exactly one bubble, then the dependent add.
    applyStimulus(32'h0000A103, 32'h300, 32'h0, 32'h0);
    checkOutput("lu lw valid", 64'(out_is_load), 64'd1);
    in_instr = 32'h001101B3; in_pc = 32'h304;
    #1;
    checkOutput("lu rs1_addr", 64'(rs1_addr), 64'd2);
    checkOutput("lu rs2_addr", 64'(rs2_addr), 64'd1);
    checkOutput("lu in_ready stalled", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    checkOutput("lu bubble valid", 64'(out_valid), 64'd0);
    checkOutput("lu bubble reg_write", 64'(out_reg_write), 64'd0);
    checkOutput("lu stall_count", 64'(stall_count), 64'd1);
    checkOutput("lu in_ready after", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    checkOutput("lu add valid", 64'(out_valid), 64'd1);
    checkOutput("lu add rd", 64'(out_rd), 64'd3);
    checkOutput("lu add pc", 64'(out_pc), 64'h304);
    idleCycle();

    // Load followed by an independent addi x4,x0,1: no bubble.
    applyStimulus(32'h0000A103, 32'h400, 32'h0, 32'h0);
    in_instr = 32'h00100213;
    #1;
    checkOutput("nodep in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    checkOutput("nodep valid", 64'(out_valid), 64'd1);
    checkOutput("nodep rd", 64'(out_rd), 64'd4);
    checkOutput("nodep stall_count", 64'(stall_count), 64'd1);
    idleCycle();

    // Back-pressure: hold addi x1,x0,5 for three cycles, then release.
    applyStimulus(32'h00500093, 32'h500, 32'h0, 32'h0);
    out_ready = 1'b0;
    in_instr = 32'h00100213; in_pc = 32'h504;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("bp%0d in_ready", c), 64'(in_ready), 64'd0);
      checkOutput($sformatf("bp%0d held", c), {out_valid, out_rd, out_imm, out_pc[15:0]},
                  {1'b1, 5'd1, 32'd5, 16'h0500});
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp release in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    checkOutput("bp next captured", {out_valid, out_rd, out_imm, out_pc[15:0]},
                {1'b1, 5'd4, 32'd1, 16'h0504});

    // Flush coincident with a valid input: the input is dropped.
    flush = 1'b1; in_instr = 32'h00700493; in_pc = 32'h600; in_valid = 1'b1;
    #1;
    checkOutput("flush in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    checkOutput("flush valid", 64'(out_valid), 64'd0);
    checkOutput("flush reg_write", 64'(out_reg_write), 64'd0);
    checkOutput("flush stall_count", 64'(stall_count), 64'd1);
    flush = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("flush dropped", 64'(out_valid), 64'd0);

    // MUL decode with and without the M subset.
    applyStimulus(32'h027302B3, 32'h700, 32'h0, 32'h0);
    checkOutput("mul alu_op", 64'(out_alu_op), 64'd10);
    checkOutput("nomul illegal", 64'(nm_out_illegal), 64'd1);
    checkOutput("nomul reg_write", 64'(nm_out_reg_write), 64'd0);
    checkOutput("nomul alu_op zeroed", 64'(nm_out_alu_op == 4'd10), 64'd0);
    idleCycle();

    // Saturating counter: the 2-bit instance stops at 3.
    loadUse(5'd2);
    loadUse(5'd2);
    checkOutput("sat wide count 3", 64'(stall_count), 64'd3);
    checkOutput("sat narrow count 3", 64'(nm_stall_count), 64'd3);
    loadUse(5'd2);
    checkOutput("sat wide count 4", 64'(stall_count), 64'd4);
    checkOutput("sat narrow held", 64'(nm_stall_count), 64'd3);

    // Asynchronous reset between clock edges discards the held instruction.
    applyStimulus(32'h00500093, 32'h800, 32'h0, 32'h0);
    checkOutput("pre-reset valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset valid", 64'(out_valid), 64'd0);
    checkOutput("async reset stall", 64'(stall_count), 64'd0);
    checkOutput("async reset rd", 64'(out_rd), 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post-reset valid", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
